// File: rtl/cdb_pkg.sv
// Shared widths, tag constants and the queued result entry type for the CDB broadcaster.
package cdb_pkg;

  localparam int ROB_W  = 6;
  localparam int DATA_W = 32;

  localparam logic [ROB_W-1:0] INVALID_ROB = 6'b010000;

  localparam int SRC_ALU    = 0;
  localparam int SRC_BRANCH = 1;
  localparam int SRC_LOAD   = 2;
  localparam int SRC_STORE  = 3;

  typedef struct packed {
    logic [ROB_W-1:0]  rob_num;
    logic [DATA_W-1:0] data;
  } cdb_entry_t;

  // Value an idle lane presents: invalid tag, zero data.
  localparam cdb_entry_t IDLE_ENTRY = '{rob_num: INVALID_ROB, data: {DATA_W{1'b0}}};

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result queue: power-of-two depth, head presented combinationally,
// flush empties it and suppresses any push/pop on the same edge.
module cdb_src_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  cdb_entry_t       wr_entry,
  output cdb_entry_t       rd_entry,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  cdb_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full check uses the pre-edge count: a full queue refuses a push even while popping.
  assign do_push = push && (count < DEPTH_C) && !flush;
  assign do_pop  = pop && (count != '0) && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/cdb_broadcaster.sv
// Common data bus broadcaster: per-source queues, round-robin arbitration onto two
// registered lanes with one-cycle cooldown. Lane 2 is enabled by CDB_DUAL_LANE_EN.
module cdb_broadcaster
  import cdb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int NUM_SRC    = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_SRC-1:0]              src_valid,
  input  logic [NUM_SRC-1:0][ROB_W-1:0]   src_rob_num,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]  src_data,
  output logic [NUM_SRC-1:0]              src_ready,
  input  logic                            flush,
  output logic                            CDBiscast,
  output logic [ROB_W-1:0]                CDBrobNum,
  output logic [DATA_W-1:0]               CDBdata,
  output logic                            CDBiscast2,
  output logic [ROB_W-1:0]                CDBrobNum2,
  output logic [DATA_W-1:0]               CDBdata2
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SRC_W:0]   NUM_SRC_C = (SRC_W + 1)'(NUM_SRC);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

  cdb_entry_t                      head [NUM_SRC];
  logic [NUM_SRC-1:0][CNT_W-1:0]   count;
  logic [NUM_SRC-1:0]              nonempty;
  logic [NUM_SRC-1:0]              pop;

  logic             stb1_q, stb2_q, stb1_d, stb2_d;
  cdb_entry_t       lane1_q, lane2_q, lane1_d, lane2_d;
  logic [SRC_W-1:0] rr_ptr, rr_d;
  logic             lane1_free, lane2_free;

  logic             first_found, second_found;
  logic [SRC_W-1:0] first_idx, second_idx, last_idx, idx;
  logic [SRC_W:0]   cand;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    cdb_entry_t wr_entry;
    assign wr_entry = '{rob_num: src_rob_num[s], data: src_data[s]};

    cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .flush    (flush),
      .push     (src_valid[s]),
      .pop      (pop[s]),
      .wr_entry (wr_entry),
      .rd_entry (head[s]),
      .count    (count[s])
    );

    assign src_ready[s] = count[s] < DEPTH_C;
    assign nonempty[s]  = count[s] != '0;
  end

  // A lane that strobed this cycle is on cooldown; the strobe register doubles as cooldown.
  assign lane1_free = !stb1_q;
`ifdef CDB_DUAL_LANE_EN
  assign lane2_free = !stb2_q;
`else
  assign lane2_free = 1'b0;
`endif

  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] i);
    logic [SRC_W:0] nxt;
    nxt = {1'b0, i} + (SRC_W + 1)'(1);
    if (nxt >= NUM_SRC_C) nxt = '0;
    return nxt[SRC_W-1:0];
  endfunction

  // Scan sources starting at rr_ptr; pick the first two non-empty queues.
  always_comb begin
    first_found  = 1'b0;
    second_found = 1'b0;
    first_idx    = '0;
    second_idx   = '0;
    cand         = '0;
    idx          = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = {1'b0, rr_ptr} + (SRC_W + 1)'(i);
      if (cand >= NUM_SRC_C) cand = cand - NUM_SRC_C;
      idx = cand[SRC_W-1:0];
      if (nonempty[idx]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = idx;
        end else if (!second_found) begin
          second_found = 1'b1;
          second_idx   = idx;
        end
      end
    end
  end

  always_comb begin
    pop      = '0;
    stb1_d   = 1'b0;
    stb2_d   = 1'b0;
    lane1_d  = IDLE_ENTRY;
    lane2_d  = IDLE_ENTRY;
    rr_d     = rr_ptr;
    last_idx = first_idx;
    if (lane1_free && first_found) begin
      stb1_d         = 1'b1;
      lane1_d        = head[first_idx];
      pop[first_idx] = 1'b1;
      if (lane2_free && second_found) begin
        stb2_d          = 1'b1;
        lane2_d         = head[second_idx];
        pop[second_idx] = 1'b1;
        last_idx        = second_idx;
      end
    end else if (lane2_free && first_found) begin
      stb2_d         = 1'b1;
      lane2_d        = head[first_idx];
      pop[first_idx] = 1'b1;
    end
    if (|pop) rr_d = wrap_inc(last_idx);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stb1_q  <= 1'b0;
      stb2_q  <= 1'b0;
      lane1_q <= IDLE_ENTRY;
      lane2_q <= IDLE_ENTRY;
      rr_ptr  <= '0;
    end else if (flush) begin
      stb1_q  <= 1'b0;
      stb2_q  <= 1'b0;
      lane1_q <= IDLE_ENTRY;
      lane2_q <= IDLE_ENTRY;
    end else begin
      stb1_q  <= stb1_d;
      stb2_q  <= stb2_d;
      lane1_q <= lane1_d;
      lane2_q <= lane2_d;
      rr_ptr  <= rr_d;
    end
  end

  assign CDBiscast  = stb1_q;
  assign CDBrobNum  = lane1_q.rob_num;
  assign CDBdata    = lane1_q.data;
  assign CDBiscast2 = stb2_q;
  assign CDBrobNum2 = lane2_q.rob_num;
  assign CDBdata2   = lane2_q.data;

endmodule
